led_sequencer: RTL and testbench

Memory-mapped controller that sequences the 8-bit LED output register. Holds a small pattern table and a period register written by the CPU, then autonomously issues timed write pulses (`led_en`/`led_wr_en`/`led_data`) to the LED register. It also arbitrates those writes against direct CPU LED writes. It sits on the peripheral bus beside the LED register and is the only master driving that register's write port.

---
 rtl/led_sequencer_pkg.sv | 31 +++
 rtl/led_seq_timer.sv | 35 +++
 rtl/led_sequencer.sv | 243 ++++++++++++++++++++++++
 tb/tb_led_sequencer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/led_sequencer_pkg.sv
// +-----------------------------------------------------------------------------+
// | Module   : led_sequencer_pkg                                                |
// | Brief    : Register map, CTRL field positions and FSM encodings shared by   |
// |            the LED sequencer files.                                         |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
`default_nettype none

package led_sequencer_pkg;

    localparam logic [3:0] c_addr_ctrl      = 4'd0;
    localparam logic [3:0] c_addr_period    = 4'd1;
    localparam logic [3:0] c_addr_direct    = 4'd2;
    localparam logic [3:0] c_addr_slot_base = 4'd8;

    localparam int c_ctrl_run     = 0;
    localparam int c_ctrl_loop    = 1;
    localparam int c_ctrl_bounce  = 2;
    localparam int c_ctrl_last_lo = 4;
    localparam int c_ctrl_last_hi = 6;

    // ADVANCE is a combinational decision, so it has no encoding of its own
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EMIT = 2'd1,
        S_HOLD = 2'd2
    } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/led_seq_timer.sv
// +-----------------------------------------------------------------------------+
// | Module   : led_seq_timer                                                    |
// | Brief    : Loadable down-counter with a zero flag; paces the HOLD state.    |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
`default_nettype none

module led_seq_timer #(
    parameter int PER_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dec,
    input  logic [PER_W-1:0] load_val,
    output logic             zero
);

    logic [PER_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - PER_W'(1);
        end
    end

    assign zero = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/led_sequencer.sv
// +-----------------------------------------------------------------------------+
// | Module   : led_sequencer                                                    |
// | Brief    : Bus-mapped pattern sequencer driving the LED register write port,|
// |            with DIRECT CPU writes taking priority. Define LEDSEQ_BOUNCE_EN  |
// |            to enable ping-pong (bounce) index order.                        |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
`default_nettype none

module led_sequencer
    import led_sequencer_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PER_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        wr_en,
    input  logic [3:0]  addr,
    input  logic [15:0] data,
    output logic [15:0] rd_data,
    output logic        led_en,
    output logic        led_wr_en,
    output logic [15:0] led_data,
    output logic        busy
);

    localparam int         c_idx_w     = $clog2(DEPTH);
    localparam logic [2:0] c_last_mask = 3'(DEPTH - 1);

    seq_state_t       r_state;
    logic             r_run;
    logic             r_loop;
    logic [2:0]       r_last;
    logic [PER_W-1:0] r_period;
    logic [7:0]       r_slot [DEPTH];
    logic [c_idx_w-1:0] r_idx;
    logic             r_busy;
    logic             r_dpend;
    logic [7:0]       r_dval;
    logic             r_led_en;
    logic [7:0]       r_led_byte;
    logic [15:0]      r_rd_data;

    logic               w_wr, w_rd, w_ctrl_wr, w_period_wr, w_direct_wr;
    logic               w_slot_sel, w_slot_wr;
    logic [c_idx_w-1:0] w_slot_idx;
    logic [c_idx_w-1:0] w_last;
    logic               w_bounce_bit;
    logic [15:0]        w_rd_val;
    logic               w_halt, w_emit_go, w_long, w_hold_done, w_advance;
    logic               w_tmr_load, w_tmr_dec, w_tmr_zero;
    logic [PER_W-1:0]   w_tmr_val;
    logic [c_idx_w-1:0] w_norm_idx, w_adv_idx;
    logic               w_norm_stop, w_adv_stop;

`ifdef LEDSEQ_BOUNCE_EN
    logic r_bounce;
    logic r_dir;     // 0 = counting up, 1 = counting down
    logic w_adv_dir;
    assign w_bounce_bit = r_bounce;
`else
    assign w_bounce_bit = 1'b0;
`endif

    assign w_wr        = en && wr_en;
    assign w_rd        = en && !wr_en;
    assign w_ctrl_wr   = w_wr && (addr == c_addr_ctrl);
    assign w_period_wr = w_wr && (addr == c_addr_period);
    assign w_direct_wr = w_wr && (addr == c_addr_direct);
    assign w_slot_sel  = addr[3] && ({1'b0, addr[2:0]} < 4'(DEPTH));
    assign w_slot_wr   = w_wr && w_slot_sel;
    assign w_slot_idx  = addr[c_idx_w-1:0];
    assign w_last      = r_last[c_idx_w-1:0];

    always_comb begin
        w_rd_val = 16'h0000;
        if (addr == c_addr_ctrl) begin
            w_rd_val = {r_busy, 4'b0000, 3'(r_idx), 1'b0, r_last, 1'b0,
                        w_bounce_bit, r_loop, r_run};
        end else if (addr == c_addr_period) begin
            w_rd_val = 16'(r_period);
        end else if (w_slot_sel) begin
            w_rd_val = {8'h00, r_slot[w_slot_idx]};
        end
    end

    // RUN=0 written to CTRL overrides any pending sequencer action this edge
    assign w_halt      = w_ctrl_wr && !data[c_ctrl_run];
    assign w_emit_go   = (r_state == S_EMIT) && !r_dpend && !w_halt;
    assign w_long      = (r_period > PER_W'(1));
    assign w_hold_done = (r_state == S_HOLD) && w_tmr_zero && !w_halt;
    assign w_advance   = (w_emit_go && !w_long) || w_hold_done;
    assign w_tmr_load  = w_emit_go && w_long;
    assign w_tmr_dec   = (r_state == S_HOLD);
    assign w_tmr_val   = r_period - PER_W'(2);

    always_comb begin
        w_norm_idx  = r_idx + c_idx_w'(1);
        w_norm_stop = 1'b0;
        if (r_idx >= w_last) begin
            w_norm_idx  = '0;
            w_norm_stop = !r_loop;
        end
    end

`ifdef LEDSEQ_BOUNCE_EN
    always_comb begin
        w_adv_idx  = w_norm_idx;
        w_adv_stop = w_norm_stop;
        w_adv_dir  = 1'b0;
        if (r_loop && r_bounce) begin
            w_adv_stop = 1'b0;
            w_adv_dir  = r_dir;
            if (w_last == '0) begin
                w_adv_idx = '0;
                w_adv_dir = 1'b0;
            end else if (!r_dir) begin
                if (r_idx >= w_last) begin
                    w_adv_idx = w_last - c_idx_w'(1);
                    w_adv_dir = 1'b1;
                end else begin
                    w_adv_idx = r_idx + c_idx_w'(1);
                end
            end else if (r_idx == '0) begin
                w_adv_idx = c_idx_w'(1);
                w_adv_dir = 1'b0;
            end else begin
                w_adv_idx = ((r_idx > w_last) ? w_last : r_idx) - c_idx_w'(1);
            end
        end
    end
`else
    assign w_adv_idx  = w_norm_idx;
    assign w_adv_stop = w_norm_stop;
`endif

    led_seq_timer #(
        .PER_W    (PER_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (w_tmr_load),
        .dec      (w_tmr_dec),
        .load_val (w_tmr_val),
        .zero     (w_tmr_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_run      <= 1'b0;
            r_loop     <= 1'b0;
            r_last     <= 3'd0;
            r_period   <= '0;
            r_idx      <= '0;
            r_busy     <= 1'b0;
            r_dpend    <= 1'b0;
            r_dval     <= 8'h00;
            r_led_en   <= 1'b0;
            r_led_byte <= 8'h00;
            r_rd_data  <= 16'h0000;
            for (int i = 0; i < DEPTH; i++) r_slot[i] <= 8'h00;
`ifdef LEDSEQ_BOUNCE_EN
            r_bounce   <= 1'b0;
            r_dir      <= 1'b0;
`endif
        end else begin
            r_led_en <= 1'b0;
            r_dpend  <= w_direct_wr;
            if (w_direct_wr) r_dval <= data[7:0];
            if (w_rd) r_rd_data <= w_rd_val;
            if (w_period_wr) r_period <= data[PER_W-1:0];
            if (w_slot_wr) r_slot[w_slot_idx] <= data[7:0];
            if (w_ctrl_wr) begin
                r_run  <= data[c_ctrl_run];
                r_loop <= data[c_ctrl_loop];
                r_last <= data[c_ctrl_last_hi:c_ctrl_last_lo] & c_last_mask;
`ifdef LEDSEQ_BOUNCE_EN
                r_bounce <= data[c_ctrl_bounce];
`endif
            end

            // A DIRECT request always owns the write port; EMIT simply waits
            if (r_dpend) begin
                r_led_en   <= 1'b1;
                r_led_byte <= r_dval;
            end else if (w_emit_go) begin
                r_led_en   <= 1'b1;
                r_led_byte <= r_slot[r_idx];
            end

            if (w_halt) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_ctrl_wr && data[c_ctrl_run]) begin
                            r_idx   <= '0;
                            r_state <= S_EMIT;
                            r_busy  <= 1'b1;
`ifdef LEDSEQ_BOUNCE_EN
                            r_dir   <= 1'b0;
`endif
                        end
                    end
                    S_EMIT, S_HOLD: begin
                        if (w_tmr_load) begin
                            r_state <= S_HOLD;
                        end else if (w_advance) begin
                            if (w_adv_stop) begin
                                r_run   <= 1'b0;
                                r_state <= S_IDLE;
                                r_busy  <= 1'b0;
                            end else begin
                                r_idx   <= w_adv_idx;
                                r_state <= S_EMIT;
`ifdef LEDSEQ_BOUNCE_EN
                                r_dir   <= w_adv_dir;
`endif
                            end
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign rd_data   = r_rd_data;
    assign led_en    = r_led_en;
    assign led_wr_en = r_led_en;
    assign led_data  = {8'h00, r_led_byte};
    assign busy      = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_led_sequencer.sv
// +-----------------------------------------------------------------------------+
// | Module   : tb_led_sequencer                                                 |
// | Brief    : Directed self-checking bench for led_sequencer.                  |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_led_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        wr_en;
    logic [3:0]  addr;
    logic [15:0] data;
    logic [15:0] rd_data;
    logic        led_en;
    logic        led_wr_en;
    logic [15:0] led_data;
    logic        busy;

    led_sequencer #(
        .DEPTH     (8),
        .PER_W     (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .wr_en     (wr_en),
        .addr      (addr),
        .data      (data),
        .rd_data   (rd_data),
        .led_en    (led_en),
        .led_wr_en (led_wr_en),
        .led_data  (led_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [7:0] v;
        int         c;
    } pulse_t;
    pulse_t q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Every LED write pulse is logged with the cycle it was seen in
    always @(negedge clk) begin
        if (led_en || led_wr_en) begin
            pulse_t p;
            check_eq("wr_mirror", 32'(led_wr_en), 32'(led_en));
            check_eq("led_hi", 32'(led_data[15:8]), 32'h0);
            p.v = led_data[7:0];
            p.c = cyc;
            q.push_back(p);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [3:0] a, input logic [15:0] d);
        en = 1'b1; wr_en = 1'b1; addr = a; data = d;
        @(posedge clk);
        #1;
        en = 1'b0; wr_en = 1'b0;
    endtask

    task automatic bus_rd(input logic [3:0] a, output logic [15:0] v);
        en = 1'b1; wr_en = 1'b0; addr = a;
        @(posedge clk);
        #1;
        en = 1'b0;
        v = rd_data;
    endtask

    task automatic check_seq(input string tag, input int n0, input int cnt, input logic [7:0] ev [8]);
        check_eq({tag, "_count"}, 32'(q.size()), 32'(cnt));
        for (int i = 0; i < cnt; i++) begin
            if (i < q.size()) begin
                check_eq({tag, "_val"}, 32'(q[i].v), 32'(ev[i]));
                check_eq({tag, "_cyc"}, 32'(q[i].c), 32'(n0 + 1 + i));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] v;
        logic [7:0]  ev [8];
        int          n0, n1;

        rst = 1'b1; en = 1'b0; wr_en = 1'b0; addr = 4'd0; data = 16'h0;
        idle(3);
        check_eq("rst_led_en", 32'(led_en), 32'h0);
        check_eq("rst_busy", 32'(busy), 32'h0);
        check_eq("rst_rd_data", 32'(rd_data), 32'h0);
        check_eq("rst_led_data", 32'(led_data), 32'h0);
        rst = 1'b0;
        idle(1);
        bus_rd(4'd0, v);
        check_eq("ctrl_after_rst", 32'(v), 32'h0);
        q.delete();
        idle(20);
        check_eq("quiet_after_rst", 32'(q.size()), 32'h0);

        bus_wr(4'd8, 16'h0001);
        bus_wr(4'd9, 16'h0002);
        bus_wr(4'd10, 16'h0004);
        bus_wr(4'd1, 16'h0003);
        bus_rd(4'd1, v);  check_eq("period_rd", 32'(v), 32'h3);
        bus_rd(4'd9, v);  check_eq("slot1_rd", 32'(v), 32'h2);
        bus_rd(4'd2, v);  check_eq("direct_rd", 32'(v), 32'h0);
        bus_rd(4'd5, v);  check_eq("unmapped_rd", 32'(v), 32'h0);

        // One-shot run, PERIOD=3
        q.delete();
        bus_wr(4'd0, 16'h0021);
        n0 = cyc;
        check_eq("oneshot_busy_hi", 32'(busy), 32'h1);
        for (int i = 0; i < 40 && busy; i++) idle(1);
        check_eq("oneshot_busy_lo", 32'(busy), 32'h0);
        ev[0] = 8'h01; ev[1] = 8'h02; ev[2] = 8'h04;
        check_eq("oneshot_count", 32'(q.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < q.size()) begin
                check_eq("oneshot_val", 32'(q[i].v), 32'(ev[i]));
                check_eq("oneshot_cyc", 32'(q[i].c), 32'(n0 + 1 + 3 * i));
            end
        end
        bus_rd(4'd0, v);
        check_eq("oneshot_run_bit", 32'(v[0]), 32'h0);
        check_eq("oneshot_ctrl", 32'(v & 16'h80FF), 32'h0020);

        // Looping run, PERIOD=3, then stop
        q.delete();
        bus_wr(4'd0, 16'h0023);
        n0 = cyc;
        idle(14);
        ev[3] = 8'h01; ev[4] = 8'h02;
        check_eq("loop_count", 32'(q.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < q.size()) begin
                check_eq("loop_val", 32'(q[i].v), 32'(ev[i]));
                check_eq("loop_cyc", 32'(q[i].c), 32'(n0 + 1 + 3 * i));
            end
        end
        bus_wr(4'd0, 16'h0000);
        n1 = q.size();
        idle(12);
        check_eq("stop_quiet", 32'(q.size()), 32'(n1));
        check_eq("stop_busy", 32'(busy), 32'h0);

        // PERIOD=0: pulse every cycle; DIRECT 0xAA collides with an EMIT
        bus_wr(4'd1, 16'h0000);
        q.delete();
        bus_wr(4'd0, 16'h0023);
        n0 = cyc;
        idle(3);
        bus_wr(4'd2, 16'h01AA);
        idle(4);
        bus_wr(4'd0, 16'h0000);
        idle(3);
        ev[0] = 8'h01; ev[1] = 8'h02; ev[2] = 8'h04; ev[3] = 8'h01;
        ev[4] = 8'hAA; ev[5] = 8'h02; ev[6] = 8'h04; ev[7] = 8'h01;
        check_seq("collide", n0, 8, ev);

        // Reset asserted while in HOLD
        bus_wr(4'd1, 16'h0005);
        q.delete();
        bus_wr(4'd0, 16'h0023);
        idle(3);
        check_eq("hold_busy", 32'(busy), 32'h1);
        rst = 1'b1;
        idle(1);
        check_eq("midrst_led_en", 32'(led_en), 32'h0);
        check_eq("midrst_busy", 32'(busy), 32'h0);
        check_eq("midrst_led_data", 32'(led_data), 32'h0);
        check_eq("midrst_rd_data", 32'(rd_data), 32'h0);
        rst = 1'b0;
        n1 = q.size();
        check_eq("midrst_pulses", 32'(n1), 32'd1);
        idle(15);
        check_eq("midrst_quiet", 32'(q.size()), 32'(n1));

        // CTRL=0x27: bounce order when enabled, plain loop otherwise
        bus_wr(4'd8, 16'h0001);
        bus_wr(4'd9, 16'h0002);
        bus_wr(4'd10, 16'h0004);
        q.delete();
        bus_wr(4'd0, 16'h0027);
        n0 = cyc;
        bus_rd(4'd0, v);
`ifdef LEDSEQ_BOUNCE_EN
        check_eq("bounce_ctrl_bits", 32'(v[2:0]), 32'h7);
        ev[0] = 8'h01; ev[1] = 8'h02; ev[2] = 8'h04; ev[3] = 8'h02;
        ev[4] = 8'h01; ev[5] = 8'h02; ev[6] = 8'h04; ev[7] = 8'h00;
`else
        check_eq("bounce_ctrl_bits", 32'(v[2:0]), 32'h3);
        ev[0] = 8'h01; ev[1] = 8'h02; ev[2] = 8'h04; ev[3] = 8'h01;
        ev[4] = 8'h02; ev[5] = 8'h04; ev[6] = 8'h01; ev[7] = 8'h00;
`endif
        idle(6);
        bus_wr(4'd0, 16'h0000);
        idle(3);
        check_seq("bounce", n0, 7, ev);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
